sopc_switch_debounce: RTL and testbench
=======================================

// Module: sopc_switch_debounce
// PURPOSE
//  Debounces and synchronises raw board slide switches and feeds clean levels into the
//  switch PIO input port (in_port) of the SOPC system. Each bit passes through a 2-FF
//  synchroniser, then a per-bit stability counter. Each bit also produces one-cycle
//  rise/fall strobes for interrupt or edge-capture logic downstream.
// PARAMETERS
//  WIDTH            4       number of switch bits
//  DEBOUNCE_CYCLES  500000  cycles a synchronised bit must differ stably before accept (10 ms @ 50 MHz); >=1
//  CNT_W            19      counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clk         in   1      system clock; one clock domain only
//  reset_n     in   1      asynchronous active-low reset
//  sw_raw      in   WIDTH  raw switch pins, asynchronous to clk, may bounce
//  sw_db       out  WIDTH  debounced level; drives PIO in_port
//  sw_rise     out  WIDTH  1-cycle strobe per bit: sw_db[i] went 0->1
//  sw_fall     out  WIDTH  1-cycle strobe per bit: sw_db[i] went 1->0
//  sw_changed  out  1      1-cycle strobe: OR of all sw_rise|sw_fall bits
// BEHAVIOUR
//  - Reset (reset_n=0, async assert, sync to clk on release): sync stages, counters,
//    sw_db, sw_rise, sw_fall and sw_changed all 0. After reset, no strobe fires until a
//    real debounced change occurs. A bit already high after reset sets sw_db to 1 through
//    the normal debounce path, with a sw_rise strobe.
//  - Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 feeds the counters.
//  - Per bit i, on each rising edge:
//     sync2[i]==sw_db[i]                 : cnt[i] <= 0 (any bounce restarts the count)
//     sync2[i]!=sw_db[i], cnt<N-1        : cnt[i] <= cnt[i]+1
//     sync2[i]!=sw_db[i], cnt==N-1       : sw_db[i] <= sync2[i]; cnt[i] <= 0; strobe
//    (N = DEBOUNCE_CYCLES)
//  - Latency: a clean raw change sampled at rising edge 1 appears on sw_db after edge N+2.
//  - Strobes: sw_rise/sw_fall/sw_changed are registered. They assert in the same cycle
//    sw_db updates, for exactly 1 cycle, and return to 0 on the next edge.
//  - Bits are fully independent. Several bits may update and strobe in the same cycle;
//    in that case sw_changed is still a single 1-cycle pulse.
//  - Glitch shorter than N cycles (after sync) never reaches sw_db. The counter does not
//    saturate or wrap: it is cleared on accept or on any equal sample.
//  - Reset mid-count discards the count and the pending change. The debounce restarts
//    from 0 after release.
//  - Outputs are purely registered; no combinational path from sw_raw to any output.
// TESTING (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
//  1 Reset: hold reset_n=0 with sw_raw=4'hF -> all outputs 0; release -> sw_db=4'hF after
//    edge 6, sw_rise=4'hF and sw_changed=1 for 1 cycle.
//  2 Clean step: sw_raw 4'h0->4'h1 before edge k -> sw_db=4'h1 after edge k+5,
//    sw_rise=4'h1 for 1 cycle, sw_fall=0.
//  3 Bounce: bit0 toggles 1,0,1,0 every 2 cycles then holds 1 -> sw_db[0] rises once, 6
//    edges after the final stable 1; exactly one sw_rise[0] pulse.
//  4 Short glitch: bit2 high for 3 cycles only -> sw_db stays 4'h0; no strobes.
//  5 Simultaneous: sw_raw 4'h5->4'hA in one cycle -> sw_db 4'hA in a single update;
//    sw_rise=4'hA, sw_fall=4'h5, sw_changed=1, all in the same single cycle.
//  6 Reset mid-count: raw bit3 set, reset_n pulsed low 2 edges later -> sw_db=0 and no
//    strobe during reset. After release, the full 6-edge latency restarts before
//    sw_db[3]=1.

Source files
------------

// File: rtl/sopc_switch_debounce_if.sv
// Switch bundle between the board pins and the debouncer: raw pins in, clean level and strobes out.
// Latency: none (wires only).
// Backpressure: none; levels and strobes are unconditional.
// Signals:
//   sw_raw     raw asynchronous switch pins (board -> debouncer)
//   sw_db      debounced level, feeds the PIO in_port
//   sw_rise    per-bit 1-cycle strobe on a debounced 0->1
//   sw_fall    per-bit 1-cycle strobe on a debounced 1->0
//   sw_changed 1-cycle strobe when any bit rose or fell
interface sopc_switch_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // Board / stimulus side: drives the raw pins, observes the clean outputs.
    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/sopc_switch_debounce.sv
// Synchronises and debounces slide switches, with per-bit rise/fall strobes for the SOPC PIO.
// Latency: a clean raw change lands on sw_db DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; outputs are registered levels and 1-cycle strobes, never stalled.
// Ports:
//   clk      single clock domain
//   reset_n  asynchronous active-low reset
//   sw_if    slave side of sopc_switch_debounce_if (sw_raw in; sw_db/sw_rise/sw_fall/sw_changed out)
module sopc_switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sopc_switch_debounce_if.slave sw_if
);

    // Count value on which the next differing sample is accepted.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            db_q;
    logic [WIDTH-1:0]            db_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic                        changed_q;
    logic                        changed_d;

    // Per-bit stability counter. Any sample equal to the current debounced level
    // restarts the count, so only an unbroken run of DEBOUNCE_CYCLES differing
    // samples is accepted. The counter never wraps: it clears on accept.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                db_d[i]   = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // One pulse no matter how many bits update together.
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            db_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sw_if.sw_raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_if.sw_db      = db_q;
    assign sw_if.sw_rise    = rise_q;
    assign sw_if.sw_fall    = fall_q;
    assign sw_if.sw_changed = changed_q;

endmodule

// File: tb/tb_sopc_switch_debounce.sv
// Directed bench for sopc_switch_debounce with WIDTH=4, DEBOUNCE_CYCLES=4.
// Latency under test: raw change before edge k appears on sw_db after edge k+5.
// Backpressure: none.
module tb_sopc_switch_debounce;

    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int CW    = 3;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    sopc_switch_debounce_if #(.WIDTH(WIDTH)) sw_if ();

    sopc_switch_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw_if  (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int rises;
    int changes;
    int hit_at;
    logic [WIDTH-1:0] cap_rise;
    logic [WIDTH-1:0] cap_fall;
    logic [WIDTH-1:0] cap_db;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // 1: reset with all switches high, then release.
        reset_n      = 1'b0;
        sw_if.sw_raw = 4'hF;
        ticks(3);
        chk("rst_db",      32'(sw_if.sw_db),      32'h0);
        chk("rst_rise",    32'(sw_if.sw_rise),    32'h0);
        chk("rst_fall",    32'(sw_if.sw_fall),    32'h0);
        chk("rst_changed", 32'(sw_if.sw_changed), 32'h0);
        reset_n = 1'b1;
        ticks(5);
        chk("rel_db_e5",   32'(sw_if.sw_db),      32'h0);
        chk("rel_chg_e5",  32'(sw_if.sw_changed), 32'h0);
        tick();
        chk("rel_db_e6",   32'(sw_if.sw_db),      32'hF);
        chk("rel_rise_e6", 32'(sw_if.sw_rise),    32'hF);
        chk("rel_fall_e6", 32'(sw_if.sw_fall),    32'h0);
        chk("rel_chg_e6",  32'(sw_if.sw_changed), 32'h1);
        tick();
        chk("rel_rise_e7", 32'(sw_if.sw_rise),    32'h0);
        chk("rel_chg_e7",  32'(sw_if.sw_changed), 32'h0);
        chk("rel_db_e7",   32'(sw_if.sw_db),      32'hF);

        // Back to all-low: every bit falls together.
        sw_if.sw_raw = 4'h0;
        ticks(6);
        chk("clr_db",   32'(sw_if.sw_db),   32'h0);
        chk("clr_fall", 32'(sw_if.sw_fall), 32'hF);
        ticks(2);

        // 2: clean single-bit step.
        sw_if.sw_raw = 4'h1;
        ticks(5);
        chk("step_db_e5",   32'(sw_if.sw_db),   32'h0);
        tick();
        chk("step_db_e6",   32'(sw_if.sw_db),   32'h1);
        chk("step_rise_e6", 32'(sw_if.sw_rise), 32'h1);
        chk("step_fall_e6", 32'(sw_if.sw_fall), 32'h0);
        tick();
        chk("step_rise_e7", 32'(sw_if.sw_rise), 32'h0);

        // 3: bounce on bit0, starting from debounced 0.
        sw_if.sw_raw = 4'h0;
        ticks(8);
        chk("bnc_pre_db", 32'(sw_if.sw_db), 32'h0);
        rises = 0;
        for (int p = 0; p < 4; p++) begin
            sw_if.sw_raw = (p % 2 == 0) ? 4'h1 : 4'h0;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (sw_if.sw_rise[0]) rises++;
            end
        end
        sw_if.sw_raw = 4'h1;
        hit_at = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (sw_if.sw_rise[0]) rises++;
            if (sw_if.sw_db[0] && hit_at == 0) hit_at = t;
        end
        chk("bnc_rise_cnt", 32'(rises),  32'd1);
        chk("bnc_latency",  32'(hit_at), 32'd6);
        chk("bnc_db",       32'(sw_if.sw_db), 32'h1);

        // 4: 3-cycle glitch on bit2 must be filtered.
        sw_if.sw_raw = 4'h0;
        ticks(8);
        changes = 0;
        sw_if.sw_raw = 4'h4;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (sw_if.sw_changed) changes++;
        end
        sw_if.sw_raw = 4'h0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (sw_if.sw_changed) changes++;
        end
        chk("glitch_strobes", 32'(changes),     32'd0);
        chk("glitch_db",      32'(sw_if.sw_db), 32'h0);

        // 5: 5 -> A in one cycle: one combined update.
        sw_if.sw_raw = 4'h5;
        ticks(8);
        chk("sim_pre_db", 32'(sw_if.sw_db), 32'h5);
        sw_if.sw_raw = 4'hA;
        changes  = 0;
        hit_at   = 0;
        cap_rise = '0;
        cap_fall = '0;
        cap_db   = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (sw_if.sw_changed) begin
                changes++;
                hit_at   = t;
                cap_rise = sw_if.sw_rise;
                cap_fall = sw_if.sw_fall;
                cap_db   = sw_if.sw_db;
            end
        end
        chk("sim_pulses", 32'(changes),  32'd1);
        chk("sim_edge",   32'(hit_at),   32'd6);
        chk("sim_rise",   32'(cap_rise), 32'hA);
        chk("sim_fall",   32'(cap_fall), 32'h5);
        chk("sim_db",     32'(cap_db),   32'hA);

        // 6: reset while bit3 is mid-count.
        sw_if.sw_raw = 4'h0;
        ticks(8);
        sw_if.sw_raw = 4'h8;
        ticks(2);
        reset_n = 1'b0;
        changes = 0;
        for (int t = 0; t < 2; t++) begin
            tick();
            if (sw_if.sw_changed) changes++;
            chk("mid_rst_db", 32'(sw_if.sw_db), 32'h0);
        end
        chk("mid_rst_strobes", 32'(changes), 32'd0);
        reset_n = 1'b1;
        ticks(5);
        chk("mid_rel_db_e5",   32'(sw_if.sw_db),   32'h0);
        tick();
        chk("mid_rel_db_e6",   32'(sw_if.sw_db),   32'h8);
        chk("mid_rel_rise_e6", 32'(sw_if.sw_rise), 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
